// File: rtl/lemmings_pkg.sv
// Shared types and helpers for the lemming walker array.
// The state encoding keeps bit 2 as the facing direction, so direction-preserving transitions are a bit test.
package lemmings_pkg;

    typedef enum logic [2:0] {
        ST_LEFT   = 3'b000,
        ST_DIG_L  = 3'b001,
        ST_FALL_L = 3'b010,
        ST_RIGHT  = 3'b100,
        ST_DIG_R  = 3'b101,
        ST_FALL_R = 3'b110,
        ST_SPLAT  = 3'b111
    } lem_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

    function automatic lem_state_t walk_state(input logic face_right);
        return face_right ? ST_RIGHT : ST_LEFT;
    endfunction

    function automatic lem_state_t dig_state(input logic face_right);
        return face_right ? ST_DIG_R : ST_DIG_L;
    endfunction

    function automatic lem_state_t fall_state(input logic face_right);
        return face_right ? ST_FALL_R : ST_FALL_L;
    endfunction

    function automatic logic is_fall(input lem_state_t s);
        return (s == ST_FALL_L) || (s == ST_FALL_R);
    endfunction

    function automatic logic is_dig(input lem_state_t s);
        return (s == ST_DIG_L) || (s == ST_DIG_R);
    endfunction

endpackage

// File: rtl/lemmings_array_fsm.sv
// One lemming walker: walk/dig/fall/splat state machine with fall and dig counters.
// Outputs are registered from the next state so they always match the state register.
module lemming_fsm
    import lemmings_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int SPLAT_LIM = 20,
    parameter int DIG_MAX   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    input  logic revive,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat,
    output logic entering_splat
);

    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] LIM_C    = CNT_W'(SPLAT_LIM);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'((DIG_MAX == 0) ? 0 : DIG_MAX - 1);
    localparam bit               DIG_LIMITED = (DIG_MAX != 0);

    lem_state_t       state;
    lem_state_t       next_state;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] dig_cnt;
    logic [2:0]       state_bits;
    logic             face_right;

    assign state_bits = state;
    assign face_right = state_bits[2];

    always_comb begin
        next_state = state;
        case (state)
            ST_LEFT, ST_RIGHT: begin
                if (!ground)
                    next_state = fall_state(face_right);
                else if (dig)
                    next_state = dig_state(face_right);
                else if (face_right ? bump_right : bump_left)
                    next_state = walk_state(!face_right);
            end
            ST_DIG_L, ST_DIG_R: begin
                if (!ground)
                    next_state = fall_state(face_right);
                else if (DIG_LIMITED && (dig_cnt == DIG_LAST))
                    next_state = walk_state(face_right);
            end
            ST_FALL_L, ST_FALL_R: begin
                // Landing checks the distance already fallen; dig and bumps are ignored mid-air.
                if (ground)
                    next_state = (fall_cnt >= LIM_C) ? ST_SPLAT : walk_state(face_right);
            end
            ST_SPLAT: begin
                if (revive)
                    next_state = ST_LEFT;
            end
            default: next_state = ST_LEFT;
        endcase
    end

    assign entering_splat = (next_state == ST_SPLAT) && (state != ST_SPLAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LEFT;
            fall_cnt   <= '0;
            dig_cnt    <= '0;
            walk_left  <= 1'b1;
            walk_right <= 1'b0;
            aaah       <= 1'b0;
            digging    <= 1'b0;
            splat      <= 1'b0;
        end else begin
            state <= next_state;
            // Counters start at zero on entry and count up while the state persists.
            if (is_fall(next_state) && is_fall(state))
                fall_cnt <= CNT_W'(sat_inc(32'(fall_cnt), CNT_MAX));
            else
                fall_cnt <= '0;
            if (is_dig(next_state) && is_dig(state))
                dig_cnt <= CNT_W'(sat_inc(32'(dig_cnt), CNT_MAX));
            else
                dig_cnt <= '0;
            walk_left  <= (next_state == ST_LEFT);
            walk_right <= (next_state == ST_RIGHT);
            aaah       <= is_fall(next_state);
            digging    <= is_dig(next_state);
            splat      <= (next_state == ST_SPLAT);
        end
    end

endmodule

// File: rtl/lemmings_array.sv
// Array of independent lemming walkers with a shared splat event pulse and a live population count.
// Both aggregate outputs are registered; alive_cnt trails the per-lemming splat outputs by one cycle.
module lemmings_array
    import lemmings_pkg::*;
#(
    parameter int N_LEM     = 4,
    parameter int CNT_W     = 8,
    parameter int SPLAT_LIM = 20,
    parameter int DIG_MAX   = 0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [N_LEM-1:0]           bump_left,
    input  logic [N_LEM-1:0]           bump_right,
    input  logic [N_LEM-1:0]           ground,
    input  logic [N_LEM-1:0]           dig,
    input  logic [N_LEM-1:0]           revive,
    output logic [N_LEM-1:0]           walk_left,
    output logic [N_LEM-1:0]           walk_right,
    output logic [N_LEM-1:0]           aaah,
    output logic [N_LEM-1:0]           digging,
    output logic [N_LEM-1:0]           splat,
    output logic                       splat_evt,
    output logic [$clog2(N_LEM+1)-1:0] alive_cnt
);

    localparam int ALIVE_W = $clog2(N_LEM + 1);

    logic [N_LEM-1:0]   entering_splat;
    logic [ALIVE_W-1:0] alive_next;

    for (genvar g = 0; g < N_LEM; g++) begin : g_lem
        lemming_fsm #(
            .CNT_W     (CNT_W),
            .SPLAT_LIM (SPLAT_LIM),
            .DIG_MAX   (DIG_MAX)
        ) u_fsm (
            .clk            (sys_clk),
            .rst            (sys_rst),
            .bump_left      (bump_left[g]),
            .bump_right     (bump_right[g]),
            .ground         (ground[g]),
            .dig            (dig[g]),
            .revive         (revive[g]),
            .walk_left      (walk_left[g]),
            .walk_right     (walk_right[g]),
            .aaah           (aaah[g]),
            .digging        (digging[g]),
            .splat          (splat[g]),
            .entering_splat (entering_splat[g])
        );
    end

    always_comb begin
        alive_next = '0;
        for (int i = 0; i < N_LEM; i++)
            alive_next = alive_next + ALIVE_W'(!splat[i]);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            splat_evt <= 1'b0;
            alive_cnt <= ALIVE_W'(N_LEM);
        end else begin
            splat_evt <= |entering_splat;
            alive_cnt <= alive_next;
        end
    end

endmodule

// File: tb/tb_lemmings_array.sv
// Self-checking bench for lemmings_array: scripted scenarios plus random traffic against a behavioural model.
module tb_lemmings_array;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int LIM  = 20;
    localparam int DMAX = 5;
    localparam int AW   = 3;
    localparam int PW   = 5 * N + 1 + AW;

    localparam int WALK = 0;
    localparam int DIGM = 1;
    localparam int FALL = 2;
    localparam int DEAD = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [N-1:0]  bump_left, bump_right, ground, dig, revive;
    logic [N-1:0]  walk_left, walk_right, aaah, digging, splat;
    logic          splat_evt;
    logic [AW-1:0] alive_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    int m_mode [N];
    int m_dir  [N];
    int m_fall [N];
    int m_dig  [N];
    int m_evt;
    int m_alive;

    logic [PW-1:0] dut_vec;
    logic [PW-1:0] exp_vec;

    lemmings_array #(
        .N_LEM     (N),
        .CNT_W     (CW),
        .SPLAT_LIM (LIM),
        .DIG_MAX   (DMAX)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .dig        (dig),
        .revive     (revive),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .splat      (splat),
        .splat_evt  (splat_evt),
        .alive_cnt  (alive_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    assign dut_vec = {walk_left, walk_right, aaah, digging, splat, splat_evt, alive_cnt};

    function automatic logic [PW-1:0] exp_pack();
        logic [N-1:0] wl, wr, fa, dg, sp;
        for (int i = 0; i < N; i++) begin
            wl[i] = (m_mode[i] == WALK) && (m_dir[i] == 0);
            wr[i] = (m_mode[i] == WALK) && (m_dir[i] == 1);
            fa[i] = (m_mode[i] == FALL);
            dg[i] = (m_mode[i] == DIGM);
            sp[i] = (m_mode[i] == DEAD);
        end
        return {wl, wr, fa, dg, sp, (m_evt != 0), AW'(m_alive)};
    endfunction

    // Reference behaviour: each lemming is a mode, a facing and how long it has been falling/digging.
    task automatic model_step();
        int alive_now;
        int evt_now;
        if (sys_rst) begin
            for (int i = 0; i < N; i++) begin
                m_mode[i] = WALK; m_dir[i] = 0; m_fall[i] = 0; m_dig[i] = 0;
            end
            m_evt = 0;
            m_alive = N;
            return;
        end
        alive_now = 0;
        evt_now   = 0;
        for (int i = 0; i < N; i++)
            if (m_mode[i] != DEAD) alive_now++;
        for (int i = 0; i < N; i++) begin
            case (m_mode[i])
                WALK: begin
                    if (!ground[i]) begin m_mode[i] = FALL; m_fall[i] = 0; end
                    else if (dig[i]) begin m_mode[i] = DIGM; m_dig[i] = 0; end
                    else if ((m_dir[i] == 0 && bump_left[i]) || (m_dir[i] == 1 && bump_right[i]))
                        m_dir[i] = 1 - m_dir[i];
                end
                DIGM: begin
                    if (!ground[i]) begin m_mode[i] = FALL; m_fall[i] = 0; end
                    else if (m_dig[i] == DMAX - 1) m_mode[i] = WALK;
                    else m_dig[i] = (m_dig[i] < 255) ? m_dig[i] + 1 : 255;
                end
                FALL: begin
                    if (ground[i]) begin
                        if (m_fall[i] >= LIM) begin m_mode[i] = DEAD; evt_now = 1; end
                        else m_mode[i] = WALK;
                    end else m_fall[i] = (m_fall[i] < 255) ? m_fall[i] + 1 : 255;
                end
                default: begin
                    if (revive[i]) begin m_mode[i] = WALK; m_dir[i] = 0; end
                end
            endcase
        end
        m_evt   = evt_now;
        m_alive = alive_now;
    endtask

    task automatic step();
        model_step();
        @(posedge sys_clk);
        #1;
        cycle++;
        exp_vec = exp_pack();
    endtask

    task automatic idle_inputs();
        bump_left = '0; bump_right = '0; ground = '1; dig = '0; revive = '0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL reset_state cycle %0d: got %h expected %h", cycle, dut_vec, exp_vec);
            end
        end
        vectors++;
        if ({walk_left, alive_cnt, splat_evt} !== {4'hF, 3'd4, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got wl=%b alive=%0d evt=%b expected wl=1111 alive=4 evt=0",
                     walk_left, alive_cnt, splat_evt);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_turn();
        bump_left[0] = 1'b1;
        step();
        vectors++;
        if (walk_right[0] !== 1'b1 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL turn_right: got %h expected %h", dut_vec, exp_vec);
        end
        step();
        vectors++;
        if (walk_right[0] !== 1'b1 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL bump_left_ignored_on_right: got %h expected %h", dut_vec, exp_vec);
        end
        bump_left[0] = 1'b0;
        bump_right[0] = 1'b1;
        step();
        bump_right[0] = 1'b0;
        vectors++;
        if (walk_left[0] !== 1'b1 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL turn_left: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_fall();
        ground[1] = 1'b0;
        for (int k = 0; k < LIM; k++) begin
            step();
            vectors++;
            if (aaah[1] !== 1'b1 || dut_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL fall_survive cycle %0d: got %h expected %h", cycle, dut_vec, exp_vec);
            end
        end
        ground[1] = 1'b1;
        step();
        vectors++;
        if (walk_left[1] !== 1'b1 || splat[1] !== 1'b0 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL land_at_limit: got %h expected %h", dut_vec, exp_vec);
        end
        ground[1] = 1'b0;
        for (int k = 0; k < LIM + 1; k++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL fall_long cycle %0d: got %h expected %h", cycle, dut_vec, exp_vec);
            end
        end
        ground[1] = 1'b1;
        step();
        vectors++;
        if ({splat[1], splat_evt, alive_cnt} !== {1'b1, 1'b1, 3'd4} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL splat_landing: got %h expected %h", dut_vec, exp_vec);
        end
        step();
        vectors++;
        if ({splat_evt, alive_cnt} !== {1'b0, 3'd3} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL splat_aftermath: got %h expected %h", dut_vec, exp_vec);
        end
        revive[1] = 1'b1;
        step();
        revive[1] = 1'b0;
        step();
        vectors++;
        if ({walk_left[1], alive_cnt} !== {1'b1, 3'd4} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL revive_ch1: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_dig();
        dig[2] = 1'b1;
        step();
        dig[2] = 1'b0;
        for (int k = 1; k <= DMAX + 1; k++) begin
            if (k > 1) step();
            vectors++;
            if (digging[2] !== (k <= DMAX) || walk_left[2] !== (k > DMAX) || dut_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL dig_limit cycle %0d: got %h expected %h", k, dut_vec, exp_vec);
            end
        end
        dig[2] = 1'b1;
        step();
        dig[2] = 1'b0;
        step();
        step();
        ground[2] = 1'b0;
        step();
        vectors++;
        if (aaah[2] !== 1'b1 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL dig_to_fall: got %h expected %h", dut_vec, exp_vec);
        end
        for (int k = 0; k < 5; k++) step();
        ground[2] = 1'b1;
        step();
        vectors++;
        if (walk_left[2] !== 1'b1 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL dig_fall_land: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_double_splat();
        ground[0] = 1'b0;
        ground[3] = 1'b0;
        for (int k = 0; k < LIM + 5; k++) step();
        ground[0] = 1'b1;
        ground[3] = 1'b1;
        step();
        vectors++;
        if ({splat[0], splat[3], splat_evt} !== 3'b111 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL double_splat: got %h expected %h", dut_vec, exp_vec);
        end
        step();
        vectors++;
        if ({splat_evt, alive_cnt} !== {1'b0, 3'd2} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL double_splat_count: got %h expected %h", dut_vec, exp_vec);
        end
        revive[3] = 1'b1;
        step();
        revive[3] = 1'b0;
        vectors++;
        if ({walk_left[3], alive_cnt} !== {1'b1, 3'd2} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL revive_ch3: got %h expected %h", dut_vec, exp_vec);
        end
        step();
        vectors++;
        if (alive_cnt !== 3'd3 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL revive_count: got %h expected %h", dut_vec, exp_vec);
        end
        revive[0] = 1'b1;
        step();
        revive[0] = 1'b0;
    endtask

    task automatic test_reset_mid_fall();
        ground[2] = 1'b0;
        for (int k = 0; k < 16; k++) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        vectors++;
        if ({aaah, walk_left, splat_evt, alive_cnt} !== {4'h0, 4'hF, 1'b0, 3'd4} || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_fall: got %h expected %h", dut_vec, exp_vec);
        end
        for (int k = 0; k < LIM; k++) step();
        ground[2] = 1'b1;
        step();
        vectors++;
        if ({walk_left[2], splat[2]} !== 2'b10 || dut_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL fall_restart: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) ground[i] = ~ground[i];
                bump_left[i]  = ($urandom_range(0, 3) == 0);
                bump_right[i] = ($urandom_range(0, 3) == 0);
                dig[i]        = ($urandom_range(0, 15) == 0);
                revive[i]     = ($urandom_range(0, 7) == 0);
            end
            sys_rst = ($urandom_range(0, 199) == 0);
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", cycle, dut_vec, exp_vec);
            end
        end
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_turn();
        test_fall();
        test_dig();
        test_double_splat();
        test_reset_mid_fall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
